// File: rtl/seq_alu.sv
// Registered two-operand ALU: single-cycle add/sub/accumulate and a shift-add
// unsigned multiply that takes WIDTH cycles, with status flags and a done pulse.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               carry,
    output logic               overflow,
    output logic               zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    logic [1:0]         state_r,    state_s;
    logic [2*WIDTH-1:0] result_r,   result_s;
    logic               busy_r,     busy_s;
    logic               done_r,     done_s;
    logic               carry_r,    carry_s;
    logic               overflow_r, overflow_s;
    logic               zero_r,     zero_s;
    logic [WIDTH-1:0]   acc_r,      acc_s;
    logic [2*WIDTH-1:0] mcand_r,    mcand_s;
    logic [WIDTH-1:0]   mplier_r,   mplier_s;
    logic [2*WIDTH-1:0] prod_r,     prod_s;
    logic [CW-1:0]      cnt_r,      cnt_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     acc_sum_s;
    logic [2*WIDTH-1:0] prod_step_s;

    // Datapath arithmetic shared by all states.
    always_comb begin
        sum_s       = {1'b0, a} + {1'b0, b};
        diff_s      = {1'b0, a} - {1'b0, b};
        acc_sum_s   = {1'b0, acc_r} + {1'b0, a};
        prod_step_s = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
    end

    // Next-state and next-output logic; flags only move on a completion.
    always_comb begin
        state_s    = state_r;
        result_s   = result_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        carry_s    = carry_r;
        overflow_s = overflow_r;
        zero_s     = zero_r;
        acc_s      = acc_r;
        mcand_s    = mcand_r;
        mplier_s   = mplier_r;
        prod_s     = prod_r;
        cnt_s      = cnt_r;

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    case (op)
                        OP_ADD: begin
                            result_s   = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
                            carry_s    = sum_s[WIDTH];
                            overflow_s = (a[WIDTH-1] == b[WIDTH-1]) &&
                                         (sum_s[WIDTH-1] != a[WIDTH-1]);
                            done_s     = 1'b1;
                            state_s    = S_DONE;
                        end
                        OP_SUB: begin
                            result_s   = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
                            carry_s    = diff_s[WIDTH];
                            overflow_s = (a[WIDTH-1] != b[WIDTH-1]) &&
                                         (diff_s[WIDTH-1] != a[WIDTH-1]);
                            done_s     = 1'b1;
                            state_s    = S_DONE;
                        end
                        OP_MUL: begin
                            mcand_s  = {{WIDTH{1'b0}}, a};
                            mplier_s = b;
                            prod_s   = {2*WIDTH{1'b0}};
                            cnt_s    = {CW{1'b0}};
                            busy_s   = 1'b1;
                            state_s  = S_MUL;
                        end
                        OP_ACC: begin
                            acc_s      = acc_sum_s[WIDTH-1:0];
                            result_s   = {{WIDTH{1'b0}}, acc_sum_s[WIDTH-1:0]};
                            carry_s    = acc_sum_s[WIDTH];
                            overflow_s = (acc_r[WIDTH-1] == a[WIDTH-1]) &&
                                         (acc_sum_s[WIDTH-1] != acc_r[WIDTH-1]);
                            done_s     = 1'b1;
                            state_s    = S_DONE;
                        end
                        default: begin
                            state_s = S_IDLE;
                        end
                    endcase
                    zero_s = (result_s == {2*WIDTH{1'b0}});
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                prod_s   = prod_step_s;
                mcand_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                // The last multiplier bit is consumed in this cycle, so the
                // product is published straight from the adder output.
                if (cnt_r == CW'(WIDTH - 1)) begin
                    result_s   = prod_step_s;
                    carry_s    = 1'b0;
                    overflow_s = 1'b0;
                    zero_s     = (prod_step_s == {2*WIDTH{1'b0}});
                    done_s     = 1'b1;
                    state_s    = S_DONE;
                end else begin
                    cnt_s  = cnt_r + CW'(1);
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            result_r   <= {2*WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b1;
            acc_r      <= {WIDTH{1'b0}};
            mcand_r    <= {2*WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            prod_r     <= {2*WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            result_r   <= result_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            carry_r    <= carry_s;
            overflow_r <= overflow_s;
            zero_r     <= zero_s;
            acc_r      <= acc_s;
            mcand_r    <= mcand_s;
            mplier_r   <= mplier_s;
            prod_r     <= prod_s;
            cnt_r      <= cnt_s;
        end
    end

    assign result   = result_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign carry    = carry_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=4; observed vector is
// {result[7:0], busy, done, carry, overflow, zero}.
module tb_seq_alu;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       carry;
    logic       overflow;
    logic       zero;

    logic [12:0] obs;
    int          checks;
    int          errors;

    seq_alu #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    assign obs = {result, busy, done, carry, overflow, zero};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (obs !== {8'd0, 5'b00001}) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", obs, {8'd0, 5'b00001});
        end
    endtask

    task automatic test_add();
        start = 1'b1; op = 2'b00; a = 4'd3; b = 4'd1;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd4, 5'b01000}) begin
            errors++;
            $display("FAIL add_3_1 got=%h exp=%h", obs, {8'd4, 5'b01000});
        end
        step();
        checks++;
        if (obs !== {8'd4, 5'b00000}) begin
            errors++;
            $display("FAIL add_hold got=%h exp=%h", obs, {8'd4, 5'b00000});
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; op = 2'b00; a = 4'd15; b = 4'd2;
        step();
        checks++;
        if (obs !== {8'd1, 5'b01100}) begin
            errors++;
            $display("FAIL add_15_2 got=%h exp=%h", obs, {8'd1, 5'b01100});
        end
        op = 2'b01; a = 4'd7; b = 4'd3;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd4, 5'b01000}) begin
            errors++;
            $display("FAIL b2b_sub_7_3 got=%h exp=%h", obs, {8'd4, 5'b01000});
        end
        step();
        checks++;
        if (obs !== {8'd4, 5'b00000}) begin
            errors++;
            $display("FAIL b2b_done_drop got=%h exp=%h", obs, {8'd4, 5'b00000});
        end
    endtask

    task automatic test_sub_borrow();
        start = 1'b1; op = 2'b01; a = 4'd7; b = 4'd8;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd15, 5'b01110}) begin
            errors++;
            $display("FAIL sub_7_8 got=%h exp=%h", obs, {8'd15, 5'b01110});
        end
        step();
    endtask

    task automatic test_mul();
        int extra_done;
        start = 1'b1; op = 2'b10; a = 4'd15; b = 4'd15;
        step();
        start = 1'b0; a = 4'd1; b = 4'd1;
        // Previous result/flags (15, borrow, overflow) must stay visible.
        checks++;
        if (obs !== {8'd15, 5'b10110}) begin
            errors++;
            $display("FAIL mul_c1_hold got=%h exp=%h", obs, {8'd15, 5'b10110});
        end
        step();
        start = 1'b1; op = 2'b00;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd15, 5'b10110}) begin
            errors++;
            $display("FAIL mul_c3_ignore got=%h exp=%h", obs, {8'd15, 5'b10110});
        end
        step();
        checks++;
        if (obs !== {8'd15, 5'b10110}) begin
            errors++;
            $display("FAIL mul_c4_busy got=%h exp=%h", obs, {8'd15, 5'b10110});
        end
        step();
        checks++;
        if (obs !== {8'hE1, 5'b01000}) begin
            errors++;
            $display("FAIL mul_15_15 got=%h exp=%h", obs, {8'hE1, 5'b01000});
        end
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) extra_done++;
        end
        checks++;
        if (extra_done !== 0 || obs !== {8'hE1, 5'b00000}) begin
            errors++;
            $display("FAIL mul_no_extra_done got=%h extra=%0d exp=%h extra=0",
                     obs, extra_done, {8'hE1, 5'b00000});
        end

        start = 1'b1; op = 2'b10; a = 4'd0; b = 4'd9;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++;
        if (obs !== {8'hE1, 5'b10000}) begin
            errors++;
            $display("FAIL mul0_c4_busy got=%h exp=%h", obs, {8'hE1, 5'b10000});
        end
        step();
        checks++;
        if (obs !== {8'd0, 5'b01001}) begin
            errors++;
            $display("FAIL mul_0_9 got=%h exp=%h", obs, {8'd0, 5'b01001});
        end
        step();
    endtask

    task automatic test_acc();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b1; op = 2'b11; a = 4'd9; b = 4'd5;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd9, 5'b01000}) begin
            errors++;
            $display("FAIL acc_first got=%h exp=%h", obs, {8'd9, 5'b01000});
        end
        step();
        start = 1'b1; op = 2'b10; a = 4'd3; b = 4'd3;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++;
        if (obs !== {8'd9, 5'b01000}) begin
            errors++;
            $display("FAIL acc_mul_3_3 got=%h exp=%h", obs, {8'd9, 5'b01000});
        end
        start = 1'b1; op = 2'b11; a = 4'd9; b = 4'd0;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd2, 5'b01110}) begin
            errors++;
            $display("FAIL acc_second got=%h exp=%h", obs, {8'd2, 5'b01110});
        end
        step();
    endtask

    task automatic test_abort();
        int stray_done;
        start = 1'b1; op = 2'b10; a = 4'd13; b = 4'd11;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== {8'd0, 5'b00001}) begin
            errors++;
            $display("FAIL abort_reset got=%h exp=%h", obs, {8'd0, 5'b00001});
        end
        stray_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) stray_done++;
        end
        checks++;
        if (stray_done !== 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d exp=0", stray_done);
        end
        start = 1'b1; op = 2'b00; a = 4'd3; b = 4'd1;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd4, 5'b01000}) begin
            errors++;
            $display("FAIL abort_then_add got=%h exp=%h", obs, {8'd4, 5'b01000});
        end
        // Accumulator was cleared by the reset, so 0+1 = 1.
        start = 1'b1; op = 2'b11; a = 4'd1; b = 4'd7;
        step();
        start = 1'b0;
        checks++;
        if (obs !== {8'd1, 5'b01000}) begin
            errors++;
            $display("FAIL acc_after_rst got=%h exp=%h", obs, {8'd1, 5'b01000});
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_borrow();
        test_mul();
        test_acc();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit two-operand switch-selected arithmetic block.
- Takes two WIDTH-bit operands and a 2-bit opcode on a start strobe.
- Executes add, subtract, iterative unsigned multiply, or accumulate, and presents a registered result with status flags and a one-cycle done pulse.
- Sits between board switch inputs (or a controlling FSM) and LED/7-segment display logic.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16; result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00 add, 01 sub, 10 mul, 11 accumulate
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted; ignored for accumulate
- result  output  2*WIDTH  last completed result, held until next completion
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when result/flags update
- carry  output  1  carry-out (add/acc) or borrow (sub); 0 for mul
- overflow  output  1  two's-complement overflow (add/sub/acc); 0 for mul
- zero  output  1  result == 0

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; result, busy, done, carry, overflow = 0; zero=1; internal accumulator = 0. This holds mid-operation: a multiply in flight is aborted with no done pulse.
- States:
  - IDLE: busy=0.
  - MUL: busy=1, WIDTH iterations.
  - DONE: one cycle, done=1, busy=0.
- Acceptance: start=1 with busy=0 at an edge accepts a request. Call the cycle in which start is sampled cycle 0.
  - Start is accepted in IDLE and in DONE (back-to-back allowed).
  - Start while busy=1 is ignored entirely; it is not queued.
- add/sub/acc (single-cycle): at the end of cycle 0, result and flags are written and state goes to DONE, so done=1 in cycle 1.
- mul: at the end of cycle 0, a and b are captured and state goes to MUL. The multiply is shift-add, one multiplier bit per cycle, for WIDTH cycles (cycles 1..WIDTH, busy=1). Result and flags are written at the end of cycle WIDTH, so done=1 in cycle WIDTH+1.
- DONE → IDLE after one cycle unless a new start is accepted. If accepted, the new single-cycle op writes its result and done stays high in the next cycle, or the new mul enters MUL.
- result and flags change only on completion; they are never visible mid-multiply.
- Arithmetic rules:
  - add: result = zero-extended {carry, a+b} low WIDTH bits; upper WIDTH bits 0; carry = bit WIDTH of a+b; overflow = a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
  - sub: diff = a-b mod 2^WIDTH, zero-extended; carry = 1 when a<b unsigned (borrow); overflow = a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].
  - mul: result = a*b unsigned, full 2*WIDTH bits, no truncation; carry = overflow = 0.
  - acc: acc <= acc + a mod 2^WIDTH; result = acc (new value) zero-extended; carry and overflow computed as for add(acc, a). The accumulator is cleared only by rst; add/sub/mul do not modify it.
- zero is computed from the full 2*WIDTH result value being written.
- Inputs a, b, op may change freely after acceptance without affecting an in-flight multiply.

Test Plan (WIDTH=4 unless stated):
- Reset, then add a=3, b=1 → cycle 1: result=4, done=1, carry=0, overflow=0, zero=0; cycle 2: done=0, result held at 4.
- add a=15, b=2 → result=1, carry=1, overflow=0. Then sub a=7, b=3 back-to-back (start asserted during the done cycle) → next cycle result=4, carry=0, done stays 1.
- sub a=7, b=8 → result=15, carry=1 (borrow), overflow=1 (7−(−8)).
- mul a=15, b=15 → busy=1 cycles 1–4, done=1 in cycle 5, result=225 (0xE1), carry=overflow=0. Start with op=add asserted in cycle 2 is ignored; no extra done pulse. mul a=0, b=9 → result=0, zero=1.
- Reset; acc a=9 → result=9, carry=0, overflow=0. acc a=9 again → result=2, carry=1, overflow=1. Intervening mul 3*3 leaves acc=9 before the second acc.
- Start mul 13*11; assert rst in cycle 2 → next cycle: busy=0, done=0, result=0, zero=1. No done pulse follows. A fresh add 3+1 afterwards completes normally with result=4.
